data_memory_unit: RTL

DATA_MEMORY_UNIT -- requirements
Module: data_memory_unit

---
 rtl/data_memory_unit_pkg.sv | 24 ++
 rtl/mem_load_align.sv | 39 +++
 rtl/data_memory_unit.sv | 122 ++++++++++++
 3 files changed

// File: rtl/data_memory_unit_pkg.sv
// Shared encodings for the data memory unit: access sizes, FSM states, size helper.
// Pure definitions; no timing or flow control.
package data_memory_unit_pkg;

  localparam logic [1:0] MEM_NONE = 2'b00;
  localparam logic [1:0] MEM_BYTE = 2'b01;
  localparam logic [1:0] MEM_HALF = 2'b10;
  localparam logic [1:0] MEM_WORD = 2'b11;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_e;

  function automatic logic [2:0] accessBytes(input logic [1:0] memNum);
    case (memNum)
      MEM_BYTE: accessBytes = 3'd1;
      MEM_HALF: accessBytes = 3'd2;
      MEM_WORD: accessBytes = 3'd4;
      default:  accessBytes = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Big-endian lane select and sign/zero extension of a memory word for loads.
// Purely combinational, zero latency; no flow control.
module mem_load_align
  import data_memory_unit_pkg::*;
(
  input  logic [31:0] memWord,
  input  logic [1:0]  byteOff,
  input  logic [1:0]  memNum,
  input  logic        unSigned,
  output logic [31:0] loadData
);

  logic [7:0]  byteLane;
  logic [15:0] halfLane;

  always_comb begin
    byteLane = 8'h00;
    // Offset 0 is the most significant byte of the word.
    case (byteOff)
      2'd0: byteLane = memWord[31:24];
      2'd1: byteLane = memWord[23:16];
      2'd2: byteLane = memWord[15:8];
      2'd3: byteLane = memWord[7:0];
      default: byteLane = 8'h00;
    endcase
    halfLane = byteOff[1] ? memWord[15:0] : memWord[31:16];
  end

  always_comb begin
    loadData = 32'h0;
    case (memNum)
      MEM_BYTE: loadData = unSigned ? {24'h0, byteLane} : {{24{byteLane[7]}}, byteLane};
      MEM_HALF: loadData = unSigned ? {16'h0, halfLane} : {{16{halfLane[15]}}, halfLane};
      MEM_WORD: loadData = memWord;
      default:  loadData = 32'h0;
    endcase
  end

endmodule

// File: rtl/data_memory_unit.sv
// Byte-addressed big-endian data memory with alignment/range checking, sticky halt and access counters.
// Loads are combinational (zero latency), stores commit at the rising edge; no backpressure, halt suppresses stores.
module data_memory_unit
  import data_memory_unit_pkg::*;
#(
  parameter int DEPTH_BYTES = 1024,
  parameter int CNT_W       = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             MemRead_i,
  input  logic             MemWrite_i,
  input  logic [1:0]       MemNum_i,
  input  logic             UnSigned_i,
  input  logic [31:0]      addr_i,
  input  logic [31:0]      wdata_i,
  output logic [31:0]      rdata_o,
  output logic             misalign_o,
  output logic             overflow_o,
  output logic             halt_o,
  output logic [CNT_W-1:0] load_cnt_o,
  output logic [CNT_W-1:0] store_cnt_o
);

  localparam int ADDR_W = $clog2(DEPTH_BYTES);
  localparam int WORDS  = DEPTH_BYTES / 4;
  localparam int IDX_W  = (ADDR_W > 2) ? ADDR_W - 2 : 1;

  logic [31:0] mem [WORDS];

  state_e      state, stateNext;
  logic        accessActive;
  logic [32:0] lastByte;
  logic        misalignDet, overflowDet, accessErr;
  logic        storeOk, loadOk;
  logic [IDX_W-1:0] wordIdx;
  logic [31:0] memWord, alignedData, wdataLanes;
  logic [3:0]  byteEn;

  assign accessActive = (MemNum_i != MEM_NONE) && (MemRead_i || MemWrite_i);

  // 33-bit sum so an access wrapping past 0xFFFFFFFF still reads as out of range.
  assign lastByte    = {1'b0, addr_i} + {30'b0, accessBytes(MemNum_i)} - 33'd1;
  assign overflowDet = accessActive && (lastByte > 33'(DEPTH_BYTES - 1));
  assign misalignDet = accessActive &&
                       (((MemNum_i == MEM_WORD) && (addr_i[1:0] != 2'b00)) ||
                        ((MemNum_i == MEM_HALF) && addr_i[0]));
  assign accessErr   = misalignDet || overflowDet;

  // Read+write together is a store; the load path still shows pre-write data.
  assign storeOk = accessActive && MemWrite_i && !accessErr && (state == RUN);
  assign loadOk  = accessActive && MemRead_i && !MemWrite_i && !accessErr && (state == RUN);

  assign wordIdx = addr_i[IDX_W+1:2];
  assign memWord = mem[wordIdx];

  mem_load_align u_align (
    .memWord  (memWord),
    .byteOff  (addr_i[1:0]),
    .memNum   (MemNum_i),
    .unSigned (UnSigned_i),
    .loadData (alignedData)
  );

  assign rdata_o = (accessActive && MemRead_i && !accessErr) ? alignedData : 32'h0;

  always_comb begin
    byteEn     = 4'b0000;
    wdataLanes = wdata_i;
    case (MemNum_i)
      MEM_BYTE: begin
        byteEn     = 4'b1000 >> addr_i[1:0];
        wdataLanes = {4{wdata_i[7:0]}};
      end
      MEM_HALF: begin
        byteEn     = addr_i[1] ? 4'b0011 : 4'b1100;
        wdataLanes = {2{wdata_i[15:0]}};
      end
      MEM_WORD: byteEn = 4'b1111;
      default:  byteEn = 4'b0000;
    endcase
  end

  // Memory is deliberately outside the reset domain; reset only blocks the write.
  always_ff @(posedge clk_i) begin
    if (!rst_i && storeOk) begin
      for (int b = 0; b < 4; b++) begin
        if (byteEn[b]) mem[wordIdx][8*b +: 8] <= wdataLanes[8*b +: 8];
      end
    end
  end

  always_comb begin
    stateNext = state;
    case (state)
      RUN:     if (accessErr) stateNext = HALTED;
      HALTED:  stateNext = HALTED;
      default: stateNext = RUN;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= RUN;
      misalign_o  <= 1'b0;
      overflow_o  <= 1'b0;
      load_cnt_o  <= '0;
      store_cnt_o <= '0;
    end else begin
      state      <= stateNext;
      misalign_o <= misalign_o | misalignDet;
      overflow_o <= overflow_o | overflowDet;
      if (loadOk && (load_cnt_o != {CNT_W{1'b1}}))
        load_cnt_o <= load_cnt_o + 1'b1;
      if (storeOk && (store_cnt_o != {CNT_W{1'b1}}))
        store_cnt_o <= store_cnt_o + 1'b1;
    end
  end

  assign halt_o = (state == HALTED);

endmodule
